// File: rtl/fifo_wr_arbiter_rr.sv
// fifo_wr_arbiter_rr: round-robin arbiter sharing one FIFO write port among
// g_N valid/ready requesters, with optional packet locking and beat limit.
//
// Optional feature macro: FIFO_WR_ARB_PKT_LOCK_EN
//   defined   -> multi-beat packets hold the grant until their last beat,
//                bounded by g_MAX_BEATS (force-release pulses o_ovf_err)
//   undefined -> grants rotate after every accepted beat
//
// Ports:
//   i_clk, i_arst        clock, async active-high reset
//   i_req_vld/dat/last   per-requester beat (data packed k*g_W)
//   o_req_rdy            per-requester accept
//   o_wena/wdat/wlast    FIFO write port; o_wsrc = written requester index
//   i_full               FIFO full backpressure
//   o_gnt                one-hot current winner (0 if none)
//   o_lock, o_ovf_err    registered lock status / force-release pulse
module fifo_wr_arbiter_rr #(
    parameter int g_N         = 4,
    parameter int g_W         = 72,
    parameter int g_MAX_BEATS = 64
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic [g_N-1:0]         i_req_vld,
    input  logic [g_N*g_W-1:0]     i_req_dat,
    input  logic [g_N-1:0]         i_req_last,
    output logic [g_N-1:0]         o_req_rdy,
    output logic                   o_wena,
    output logic [g_W-1:0]         o_wdat,
    output logic                   o_wlast,
    output logic [$clog2(g_N)-1:0] o_wsrc,
    input  logic                   i_full,
    output logic [g_N-1:0]         o_gnt,
    output logic                   o_lock,
    output logic                   o_ovf_err
);

    localparam int IW = $clog2(g_N);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_nxt;
    logic          found;
    logic [IW-1:0] win;
    logic          acc;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    logic          lock;
    logic          lock_nxt;
    logic [IW-1:0] lock_idx;
    logic [IW-1:0] lock_idx_nxt;
    logic [15:0]   beat_cnt;
    logic [15:0]   beat_cnt_nxt;
    logic          ovf;
    logic          ovf_nxt;
    logic          at_limit;
`endif

    // (base + off) mod g_N for off in 1..g_N
    function automatic logic [IW-1:0] rr_idx(
        input logic [IW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= g_N) s = s - g_N;
        return IW'(s);
    endfunction

    // Winner selection: the lock owner if locked, else first valid
    // requester after the last one served.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= g_N; i++) begin
            if (!found && i_req_vld[rr_idx(rr_ptr, i)]) begin
                found = 1'b1;
                win   = rr_idx(rr_ptr, i);
            end
        end
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        if (lock) begin
            found = 1'b1;
            win   = lock_idx;
        end
`endif
    end

    assign acc = found & i_req_vld[win] & ~i_full & ~i_arst;

    // State register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rr_ptr   <= IW'(g_N - 1);
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
            lock     <= 1'b0;
            lock_idx <= '0;
            beat_cnt <= '0;
            ovf      <= 1'b0;
`endif
        end else begin
            rr_ptr   <= rr_ptr_nxt;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
            lock     <= lock_nxt;
            lock_idx <= lock_idx_nxt;
            beat_cnt <= beat_cnt_nxt;
            ovf      <= ovf_nxt;
`endif
        end
    end

    // Next-state logic
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    assign at_limit = ({1'b0, beat_cnt} + 17'd1) == 17'(g_MAX_BEATS);

    always_comb begin
        rr_ptr_nxt   = rr_ptr;
        lock_nxt     = lock;
        lock_idx_nxt = lock_idx;
        beat_cnt_nxt = beat_cnt;
        ovf_nxt      = 1'b0;
        if (acc) begin
            if (i_req_last[win] || at_limit) begin
                // End of packet, or beat limit reached: release and let
                // the rest of an over-long packet re-arbitrate.
                lock_nxt     = 1'b0;
                rr_ptr_nxt   = win;
                beat_cnt_nxt = '0;
                ovf_nxt      = ~i_req_last[win];
            end else begin
                lock_nxt     = 1'b1;
                lock_idx_nxt = win;
                beat_cnt_nxt = beat_cnt + 16'd1;
            end
        end
    end
`else
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (acc) rr_ptr_nxt = win;
    end
`endif

    // Output logic; everything on the write side is zero during reset
    always_comb begin
        o_wena    = acc;
        o_req_rdy = '0;
        o_gnt     = '0;
        o_wdat    = '0;
        o_wlast   = 1'b0;
        o_wsrc    = '0;
        if (acc) o_req_rdy[win] = 1'b1;
        if (found && !i_arst) begin
            o_gnt[win] = 1'b1;
            o_wdat     = i_req_dat[int'(win)*g_W +: g_W];
            o_wlast    = i_req_last[win];
            o_wsrc     = win;
        end
    end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    assign o_lock    = lock;
    assign o_ovf_err = ovf;
`else
    assign o_lock    = 1'b0;
    assign o_ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter_rr.sv
// Testbench for fifo_wr_arbiter_rr: requester queues drive the arbiter and
// a packet-level reference model predicts every combinational output.
module tb_fifo_wr_arbiter_rr;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXB = 4;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           arst = 1'b1;
    logic [N-1:0]   req_vld = '0;
    logic [N*W-1:0] req_dat = '0;
    logic [N-1:0]   req_last = '0;
    logic           full = 1'b0;
    logic [N-1:0]   req_rdy;
    logic           wena;
    logic [W-1:0]   wdat;
    logic           wlast;
    logic [1:0]     wsrc;
    logic [N-1:0]   gnt;
    logic           lock;
    logic           ovf_err;

    fifo_wr_arbiter_rr #(.g_N(N), .g_W(W), .g_MAX_BEATS(MAXB)) dut (
        .i_clk(clk), .i_arst(arst),
        .i_req_vld(req_vld), .i_req_dat(req_dat), .i_req_last(req_last),
        .o_req_rdy(req_rdy), .o_wena(wena), .o_wdat(wdat),
        .o_wlast(wlast), .o_wsrc(wsrc), .i_full(full),
        .o_gnt(gnt), .o_lock(lock), .o_ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // requester beat queues: {last, data}
    logic [8:0] q [N][$];
    logic [N-1:0] bubble = '0;

    // reference model: packet owner, last served requester, beats so far
    int m_owner, m_last, m_beats;
    bit m_ovf;
    int e_win;
    bit e_acc;
    logic [21:0] exp_vec;
    wire  [21:0] dut_vec = {wena, req_rdy, gnt, wsrc, wdat, wlast, lock, ovf_err};

    int vectors = 0;
    int miscompares = 0;
    int obs_src[$];
    logic [7:0] obs_dat[$];

    task automatic drive(input logic f);
        logic [8:0] b;
        full = f;
        for (int k = 0; k < N; k++) begin
            if (q[k].size() > 0 && !bubble[k]) begin
                b = q[k][0];
                req_vld[k] = 1'b1;
                req_dat[k*W +: W] = b[7:0];
                req_last[k] = b[8];
            end else begin
                req_vld[k] = 1'b0;
                req_dat[k*W +: W] = 8'($urandom);
                req_last[k] = 1'($urandom);
            end
        end
    endtask

    function automatic void model_eval();
        logic [N-1:0] rdy = '0;
        logic [N-1:0] g = '0;
        logic [7:0] d = '0;
        logic l = 1'b0;
        logic [1:0] s = '0;
        e_win = -1;
        if (m_owner >= 0) e_win = m_owner;
        else
            for (int off = 1; off <= N; off++)
                if (e_win < 0 && req_vld[(m_last + off) % N])
                    e_win = (m_last + off) % N;
        e_acc = (e_win >= 0) && req_vld[e_win] && !full;
        if (e_win >= 0) begin
            g[e_win] = 1'b1;
            d = req_dat[e_win*W +: W];
            l = req_last[e_win];
            s = 2'(e_win);
            if (e_acc) rdy[e_win] = 1'b1;
        end
        exp_vec = {e_acc, rdy, g, s, d, l, (m_owner >= 0), m_ovf};
    endfunction

    task automatic tick();
        if (wena) begin
            obs_src.push_back(int'(wsrc));
            obs_dat.push_back(wdat);
        end
        @(posedge clk);
        m_ovf = 1'b0;
        if (e_acc) begin
            void'(q[e_win].pop_front());
            if (!LOCK_EN || req_last[e_win]) begin
                m_owner = -1; m_last = e_win; m_beats = 0;
            end else begin
                m_beats++;
                if (m_beats == MAXB) begin
                    m_owner = -1; m_last = e_win; m_beats = 0; m_ovf = 1'b1;
                end else m_owner = e_win;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        arst = 1'b1;
        for (int k = 0; k < N; k++) q[k].delete();
        bubble = '0;
        req_vld = '1;
        req_dat = N*W'($urandom);
        req_last = 4'($urandom);
        full = 1'b0;
        m_owner = -1; m_last = N - 1; m_beats = 0; m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        arst = 1'b0;
        obs_src.delete();
        obs_dat.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (dut_vec !== 22'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h need=%h", dut_vec, 22'h0);
        end
        release_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_idle c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int es[5] = '{0, 1, 2, 3, 0};
        obs_src.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) q[k].push_back({1'b1, 8'(8'h10 + 16*r + k)});
        for (int c = 0; c < 8; c++) begin
            drive(1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rr c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            if (c < 5) begin
                vectors++;
                if (wena !== 1'b1 || int'(wsrc) != es[c]) begin
                    miscompares++;
                    $display("FAIL rr_src c%0d got=%0d/%b need=%0d/1", c, wsrc, wena, es[c]);
                end
            end
            tick();
        end
    endtask

    task automatic test_packet_lock();
        int es[4] = '{2, 2, 2, 1};
        logic [7:0] ed[4] = '{8'hA0, 8'hA1, 8'hA2, 8'h52};
        int nlock = 0;
        q[1].push_back({1'b1, 8'h51});
        drive(1'b0); @(negedge clk); model_eval(); tick();
        obs_src.delete(); obs_dat.delete();
        q[2].push_back({1'b0, 8'hA0});
        q[2].push_back({1'b0, 8'hA1});
        q[2].push_back({1'b1, 8'hA2});
        for (int i = 0; i < 3; i++) q[1].push_back({1'b1, 8'(8'h52 + i)});
        for (int c = 0; c < 6; c++) begin
            drive(1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL lock c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            if (c < 4 && lock === 1'b1) nlock++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs_src.size() <= i || obs_src[i] != es[i] || obs_dat[i] !== ed[i]) begin
                miscompares++;
                $display("FAIL lock_seq i%0d need=%0d:%h", i, es[i], ed[i]);
            end
        end
        vectors++;
        if (nlock != 2) begin
            miscompares++;
            $display("FAIL lock_cycles got=%0d need=2", nlock);
        end
    endtask

    task automatic test_bubble();
        q[2].push_back({1'b0, 8'hB0});
        q[2].push_back({1'b0, 8'hB1});
        q[2].push_back({1'b1, 8'hB2});
        q[0].push_back({1'b1, 8'hC0});
        for (int c = 0; c < 6; c++) begin
            bubble = (c == 1 || c == 2) ? 4'b0100 : 4'b0000;
            drive(1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bubble c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            if (c == 1 || c == 2) begin
                vectors++;
                if (wena !== 1'b0 || req_rdy[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bubble_stall c%0d got=%b/%b need=0/0", c, wena, req_rdy[0]);
                end
            end
            tick();
        end
        bubble = '0;
    endtask

    task automatic test_full();
        obs_dat.delete();
        q[3].push_back({1'b0, 8'hD0});
        q[3].push_back({1'b0, 8'hD1});
        q[3].push_back({1'b1, 8'hD2});
        for (int c = 0; c < 6; c++) begin
            drive(c >= 1 && c <= 3);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL full c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            if (c >= 1 && c <= 3) begin
                vectors++;
                if (gnt !== 4'b1000 || wena !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_hold c%0d got=%b/%b need=1000/0", c, gnt, wena);
                end
            end
            tick();
        end
        vectors++;
        if (obs_dat.size() != 3 || obs_dat[1] !== 8'hD1) begin
            miscompares++;
            $display("FAIL full_resume got=%0d beats need=3 with D1 second", obs_dat.size());
        end
    endtask

    task automatic test_overflow();
        int es[8] = '{3, 3, 3, 3, 0, 1, 3, 3};
        int novf = 0;
        obs_src.delete();
        for (int i = 0; i < 6; i++) q[3].push_back({1'b0, 8'(8'hE0 + i)});
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                q[0].push_back({1'b1, 8'hF0});
                q[1].push_back({1'b1, 8'hF1});
            end
            drive(1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL ovf c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            if (ovf_err === 1'b1) novf++;
            if (c == 4) begin
                vectors++;
                if (ovf_err !== 1'b1 || lock !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_release got=%b/%b need=1/0", ovf_err, lock);
                end
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs_src.size() <= i || obs_src[i] != es[i]) begin
                miscompares++;
                $display("FAIL ovf_seq i%0d need=%0d", i, es[i]);
            end
        end
        vectors++;
        if (novf != 1) begin
            miscompares++;
            $display("FAIL ovf_pulses got=%0d need=1", novf);
        end
        apply_reset();
        vectors++;
        if (dut_vec !== 22'h0) begin
            miscompares++;
            $display("FAIL midpkt_reset got=%h need=%h", dut_vec, 22'h0);
        end
        release_reset();
    endtask

    task automatic test_interleave();
        int es[6] = '{0, 1, 0, 1, 0, 1};
        obs_src.delete();
        for (int i = 0; i < 3; i++) begin
            q[0].push_back({i == 2, 8'(8'h30 + i)});
            q[1].push_back({i == 2, 8'(8'h40 + i)});
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b0);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL ilv c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            vectors++;
            if (wena !== 1'b1 || int'(wsrc) != es[c]) begin
                miscompares++;
                $display("FAIL ilv_src c%0d got=%0d need=%0d", c, wsrc, es[c]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int len;
        int k;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, N - 1);
                if (q[k].size() < 8) begin
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++)
                        q[k].push_back({i == len - 1, 8'($urandom)});
                end
            end
            bubble = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
            drive($urandom_range(0, 4) == 0);
            @(negedge clk); model_eval();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL rand c%0d got=%h need=%h", c, dut_vec, exp_vec);
            end
            tick();
        end
        bubble = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        if (LOCK_EN) begin
            test_packet_lock();
            test_bubble();
            test_full();
            test_overflow();
        end else begin
            apply_reset();
            release_reset();
            test_interleave();
        end
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter_rr.md
# fifo_wr_arbiter_rr

Round-robin write arbiter that shares the write port of one single-clock SRAM FIFO (`fifo_sync_sram_based`) among `g_N` valid/ready requesters. It sits directly in front of the FIFO write port and drives `i_wena`/`i_wdat` from the winning requester. It takes backpressure from the FIFO's `o_full`. Packet locking keeps multi-beat packets contiguous in the FIFO, and a beat limit bounds how long one requester can hold the port.

## Interface
Parameters:
- `g_N`, 4: number of requesters, 2..16.
- `g_W`, 72: data width; must match the FIFO `g_W`.
- `g_MAX_BEATS`, 64: maximum beats per locked grant, 1..65535.

Ports:
- `i_clk`  in  1  sole clock; all state on the rising edge.
- `i_arst`  in  1  asynchronous, active-high reset.
- `i_req_vld`  in  g_N  per-requester beat valid.
- `i_req_dat`  in  g_N*g_W  packed data; requester k at `[k*g_W +: g_W]`.
- `i_req_last`  in  g_N  per-requester last beat of packet.
- `o_req_rdy`  out  g_N  per-requester accept.
- `o_wena`  out  1  FIFO write enable.
- `o_wdat`  out  g_W  FIFO write data.
- `o_wlast`  out  1  last flag of the written beat.
- `o_wsrc`  out  $clog2(g_N)  index of the written requester.
- `i_full`  in  1  FIFO `o_full`.
- `o_gnt`  out  g_N  one-hot current winner; 0 when there is no winner.
- `o_lock`  out  1  packet lock active.
- `o_ovf_err`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- State: `lock` (1b), `lock_idx`, `rr_ptr` (last served index), `beat_cnt` (16b).
- UNLOCKED: the winner is the first k with `i_req_vld[k]`=1, searched from `(rr_ptr+1) mod g_N` upward with wrap.
- LOCKED: the winner is `lock_idx`, regardless of other valids. A bubble from `lock_idx` stalls the port and no other requester is served.
- Beat accept: `acc = winner exists & i_req_vld[winner] & ~i_full`.
  - `o_wena = acc`.
  - `o_req_rdy[k] = acc & (k==winner)`.
  - `o_wdat`, `o_wlast`, `o_wsrc` are taken from the winner. They are 0 when there is no winner.
- On acc with `i_req_last`=1, go to UNLOCKED:
  - `rr_ptr` <= winner.
  - `beat_cnt` <= 0.
- On acc with `i_req_last`=0:
  - LOCKED, `lock_idx` <= winner.
  - `beat_cnt` <= `beat_cnt`+1.
- Forced release: on acc with `i_req_last`=0 and `beat_cnt`+1 == `g_MAX_BEATS`:
  - Go to UNLOCKED, `rr_ptr` <= winner, `beat_cnt` <= 0.
  - Pulse `o_ovf_err` in the next cycle.
  - The remainder of that packet re-arbitrates as a new packet.
- `i_full`=1: no accept. State holds and `o_gnt` still shows the winner.
- Requester order is guaranteed only at packet granularity. Within a packet, beats reach the FIFO in order.

## Timing
- Accept path is combinational: a beat presented in cycle t with `i_full`=0 is written by the FIFO at the edge that ends cycle t. Zero added latency.
- Combinational outputs: `o_req_rdy`, `o_wena`, `o_wdat`, `o_wlast`, `o_wsrc`, `o_gnt`.
- Registered outputs: `o_lock`, `o_ovf_err`.
- Throughput: one beat per cycle, sustained while the FIFO is not full, including back-to-back packets from different requesters.
- Reset (`i_arst`=1, async assert, release synchronised externally):
  - State values: `lock`=0, `rr_ptr`=g_N-1 (requester 0 has first priority), `beat_cnt`=0, `o_ovf_err`=0.
  - While reset is asserted, `o_wena`, `o_req_rdy`, `o_gnt`, `o_wdat`, `o_wlast` and `o_wsrc` are forced to 0.
- Reset mid-packet drops the lock. The upstream requester is responsible for restarting its packet.
- A single-beat packet (`i_req_last`=1 on the first beat) never sets the lock.

## Configuration
- `FIFO_WR_ARB_PKT_LOCK_EN` defined:
  - Packet locking and forced release operate as described above.
  - `beat_cnt` and `o_ovf_err` are present.
- `FIFO_WR_ARB_PKT_LOCK_EN` undefined:
  - Every accepted beat is treated as last for arbitration, so grants rotate beat-by-beat.
  - `o_lock` and `o_ovf_err` are tied to 0 and `beat_cnt` is removed.
  - `o_wlast` still passes `i_req_last` through.

## Test plan
Bench configuration: g_N=4, g_W=8, g_MAX_BEATS=4; macro defined unless noted.
- Reset release, all four valid with single-beat packets, `i_full`=0 → writes src 0,1,2,3,0 on consecutive cycles, with `o_wena`=1 every cycle.
- Requester 2 sends 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2) while requester 1 is continuously valid → FIFO receives 0xA0,0xA1,0xA2 contiguously, then src 1. `o_lock`=1 for 2 cycles.
- Locked on requester 2, which drops valid for 2 cycles while requester 0 is valid → `o_wena`=0 for those 2 cycles and `o_req_rdy[0]`=0.
- `i_full`=1 for 3 cycles mid-packet → no writes, `o_gnt` stable. The first beat after `i_full` drops equals the stalled beat.
- Requester 3 sends 6 beats with no last → after beat 4, `o_ovf_err` pulses once and `o_lock` goes to 0. Other valid requesters are then served before requester 3 resumes.
- Macro undefined, requesters 0 and 1 both send 3-beat packets → writes interleave as src 0,1,0,1,0,1.
